// File: rtl/uart_tx_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_bridge
// Purpose : Buffers uart_rx byte strobes in a FIFO and launches them one at a
//           time into uart_tx. Optional counters: UART_BRIDGE_STATS_EN.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo_bridge #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  output logic [ADDR_W:0]   fifo_count,
  output logic              empty,
  output logic              full,
  output logic              overflow
`ifdef UART_BRIDGE_STATS_EN
  ,
  output logic [15:0]       drop_count,
  output logic [15:0]       tx_count
`endif
);

  localparam logic [ADDR_W:0] c_full_count = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic                tx_dv_q, tx_dv_d;
  logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                push, drop, launch;

  // Full is judged on the pre-edge occupancy, so a same-edge pop never rescues a byte.
  always_comb begin
    push       = in_valid && !full_q;
    drop       = in_valid && full_q;
    launch     = 1'b0;
    state_d    = state_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    overflow_d = overflow_q || drop;

    case (state_q)
      IDLE: begin
        if (!empty_q && !tx_active) begin
          launch    = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          tx_dv_d   = 1'b1;
          rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(launch);
    empty_d = (count_d == '0);
    full_d  = (count_d == c_full_count);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign fifo_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = overflow_q;

`ifdef UART_BRIDGE_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] tx_count_q, tx_count_d;

  // Drops saturate; launches wrap.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
    tx_count_d = tx_count_q + 16'(launch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
      tx_count_q   <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      tx_count_q   <= tx_count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign tx_count   = tx_count_q;
`endif

endmodule
`default_nettype wire
